vga_text_console: RTL and testbench

//  Text-mode write controller for the character RAM write port. It accepts a

---
 rtl/vga_text_console_if.sv | 28 ++
 rtl/vga_text_console.sv | 152 +++++++++++++++
 tb/tb_vga_text_console.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_console_if.sv
// Byte-stream input and char RAM write-port bundle for the text console.
// The slave side is the console; the master side is the source/observer.
interface vga_text_console_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 7
) ();
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_wr_en;
  logic [6:0]            cursor_x;
  logic [4:0]            cursor_y;
  logic                  busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, ram_addr, ram_data, ram_wr_en,
    input  cursor_x, cursor_y, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ram_addr, ram_data, ram_wr_en,
    output cursor_x, cursor_y, busy
  );
endinterface

// File: rtl/vga_text_console.sv
// Text-mode write controller: turns a byte stream into char RAM writes
// and cursor moves, including a full-screen clear fill.
module vga_text_console #(
  parameter int                    COLS       = 80,
  parameter int                    ROWS       = 30,
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 7,
  parameter logic [DATA_WIDTH-1:0] CLEAR_CHAR = 7'h20
) (
  input logic               clk,
  input logic               rst,
  vga_text_console_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [6:0] XMAX = 7'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [6:0]            x_q, x_d;
  logic [4:0]            y_q, y_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic [7:0]            b;
  logic                  is_print;
  logic [ADDR_WIDTH-1:0] lin_addr;
  logic [4:0]            y_inc;

  assign accept   = in_ready_q & bus.in_valid;
  assign b        = bus.in_data;
  assign is_print = (b >= 8'h20) && (b <= 8'h7E);
  assign lin_addr = ADDR_WIDTH'(y_q) * ADDR_WIDTH'(COLS)
                  + ADDR_WIDTH'(x_q);
  assign y_inc    = (y_q == YMAX) ? 5'd0 : y_q + 5'd1;

  // Next-state, cursor and RAM write decode.
  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    x_d        = x_q;
    y_d        = y_q;
    busy_d     = busy_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (accept) begin
          unique case (1'b1)
            is_print: begin
              state_d    = WRITE;
              in_ready_d = 1'b0;
              wr_en_d    = 1'b1;
              addr_d     = lin_addr;
              data_d     = DATA_WIDTH'(b[6:0]);
              if (x_q == XMAX) begin
                x_d = 7'd0;
                y_d = y_inc;
              end else begin
                x_d = x_q + 7'd1;
              end
            end
            (b == 8'h0D): x_d = 7'd0;
            (b == 8'h0A): begin
              x_d = 7'd0;
              y_d = y_inc;
            end
            (b == 8'h08): begin
              if (x_q != 7'd0) begin
                x_d = x_q - 7'd1;
              end else if (y_q != 5'd0) begin
                x_d = XMAX;
                y_d = y_q - 5'd1;
              end
            end
            (b == 8'h0C): begin
              state_d    = CLEAR;
              in_ready_d = 1'b0;
              busy_d     = 1'b1;
              wr_en_d    = 1'b1;
              addr_d     = '0;
              data_d     = CLEAR_CHAR;
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
      CLEAR: begin
        if (addr_q == LAST) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          in_ready_d = 1'b1;
          x_d        = 7'd0;
          y_d        = 5'd0;
        end else begin
          wr_en_d = 1'b1;
          addr_d  = addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any write or fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      x_q        <= x_d;
      y_q        <= y_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ram_wr_en = wr_en_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_data  = data_q;
  assign bus.cursor_x  = x_q;
  assign bus.cursor_y  = y_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_vga_text_console.sv
// Scoreboarded bench for vga_text_console: expected RAM writes are
// queued by the stimulus and popped by a negedge monitor.
module tb_vga_text_console;
  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_text_console_if #(.ADDR_WIDTH(12), .DATA_WIDTH(7)) bus ();

  vga_text_console dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [6:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int addr, input int data);
    wr_t w;
    w.addr = 12'(addr);
    w.data = 7'(data);
    exp_q.push_back(w);
  endtask

  // Monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) begin
        vectors++;
        if (bus.in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL ready_in_clear: got %b, expected 0",
                   bus.in_ready);
        end
      end
      if (bus.ram_wr_en) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: addr %0d data %h",
                   bus.ram_addr, bus.ram_data);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          if (bus.ram_addr !== w.addr || bus.ram_data !== w.data) begin
            miscompares++;
            $display("FAIL ram_write: got %0d/%h, expected %0d/%h",
                     bus.ram_addr, bus.ram_data, w.addr, w.data);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      check("ready_timeout", 0, 1);
    end
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cur(input string name, input int x, input int y);
    check({name, "_x"}, int'(bus.cursor_x), x);
    check({name, "_y"}, int'(bus.cursor_y), y);
  endtask

  initial begin
    int cnt;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    #1;
    check("rst_ready", int'(bus.in_ready), 0);
    check("rst_wr_en", int'(bus.ram_wr_en), 0);
    check("rst_addr", int'(bus.ram_addr), 0);
    check("rst_busy", int'(bus.busy), 0);
    cur("rst_cur", 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", int'(bus.in_ready), 1);

    // 1: single printable
    push(0, 8'h41);
    send(8'h41);
    check("a_wr_en", int'(bus.ram_wr_en), 1);
    check("a_ready_low", int'(bus.in_ready), 0);
    cur("a_cur", 1, 0);
    @(posedge clk);
    #1;
    check("a_ready_back", int'(bus.in_ready), 1);
    check("a_wr_off", int'(bus.ram_wr_en), 0);

    // 2: full row then wrap to next row
    send(8'h0D);
    cur("cr", 0, 0);
    for (int i = 0; i < 80; i++) begin
      push(i, 8'h42);
      send(8'h42);
    end
    cur("row_wrap", 0, 1);
    push(80, 8'h43);
    send(8'h43);
    cur("c_cur", 1, 1);

    // 3: bottom row and vertical wrap
    send(8'h0D);
    for (int i = 0; i < 28; i++) send(8'h0A);
    cur("lf28", 0, 29);
    push(2320, 8'h5A);
    send(8'h5A);
    cur("z_cur", 1, 29);
    send(8'h0A);
    cur("lf_wrap", 0, 0);

    // 4: full clear from a non-home cursor
    send(8'h0A);
    send(8'h0A);
    push(160 + 0, 8'h31);
    send(8'h31);
    cur("pre_ff", 1, 2);
    for (int i = 0; i < 2400; i++) push(i, 8'h20);
    send(8'h0C);
    cnt = 0;
    while (bus.busy && cnt < 3000) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    check("ff_busy_cycles", cnt, 2400);
    cur("ff_cur", 0, 0);
    check("ff_ready", int'(bus.in_ready), 1);
    check("ff_queue_empty", exp_q.size(), 0);

    // 5: reset in the middle of a clear
    send(8'h0A);
    for (int i = 0; i < 2400; i++) push(i, 8'h20);
    send(8'h0C);
    repeat (1000) @(posedge clk);
    #1;
    check("mid_addr", int'(bus.ram_addr), 1000);
    rst = 1'b1;
    #1;
    check("rst_mid_wr_en", int'(bus.ram_wr_en), 0);
    check("rst_mid_busy", int'(bus.busy), 0);
    check("rst_mid_addr", int'(bus.ram_addr), 0);
    cur("rst_mid_cur", 0, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    push(0, 8'h51);
    send(8'h51);
    cur("q_cur", 1, 0);

    // 6: backspace and ignored bytes
    send(8'h08);
    cur("bs_1", 0, 0);
    send(8'h08);
    cur("bs_home", 0, 0);
    for (int i = 0; i < 3; i++) send(8'h0A);
    cur("lf3", 0, 3);
    send(8'h08);
    cur("bs_up", 79, 2);
    send(8'h07);
    cur("bel", 79, 2);
    check("bel_ready", int'(bus.in_ready), 1);
    send(8'h80);
    cur("x80", 79, 2);
    send(8'h7F);
    cur("del", 79, 2);
    push(239, 8'h7E);
    send(8'h7E);
    cur("tilde_wrap", 0, 3);

    repeat (4) @(posedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
